// File: rtl/clk_gate_ctrl.sv
// Per-channel ICG enable sequencer with round-robin wake arbitration (one wake per cycle).
// Outputs registered: gate_en one edge after grant, ack WAKE_CYCLES later; no backpressure, req is a level.
module clk_gate_ctrl #(
    parameter int NUM_CH      = 4,
    parameter int WAKE_CYCLES = 2,
    parameter int IDLE_CYCLES = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NUM_CH-1:0] req,
    input  logic              force_on,
    output logic [NUM_CH-1:0] gate_en,
    output logic [NUM_CH-1:0] ack,
    output logic              busy
);

    typedef enum logic [1:0] {OFF, WAKE, ON, HOLD} state_t;

    localparam int         PW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [3:0] WAKE_LOAD = 4'(WAKE_CYCLES - 1);
    localparam logic [3:0] IDLE_LOAD = 4'(IDLE_CYCLES - 1);

    state_t            state     [NUM_CH];
    state_t            state_nxt [NUM_CH];
    logic [3:0]        cnt       [NUM_CH];
    logic [3:0]        cnt_nxt   [NUM_CH];
    logic [PW-1:0]     rr_ptr;
    logic [PW-1:0]     rr_ptr_nxt;
    logic [PW-1:0]     winner;
    logic              grant_vld;
    logic [NUM_CH-1:0] grant;
    logic [NUM_CH-1:0] gate_en_nxt;
    logic [NUM_CH-1:0] ack_nxt;
    logic              busy_nxt;

    // Round-robin search over OFF channels with a pending request, starting at rr_ptr.
    always_comb begin
        logic [PW:0]   sum;
        logic [PW-1:0] idx;
        grant_vld  = 1'b0;
        winner     = '0;
        grant      = '0;
        sum        = '0;
        idx        = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            sum = {1'b0, rr_ptr} + (PW+1)'(k);
            if (sum >= (PW+1)'(NUM_CH))
                sum = sum - (PW+1)'(NUM_CH);
            idx = sum[PW-1:0];
            if (!grant_vld && state[idx] == OFF && req[idx]) begin
                grant_vld   = 1'b1;
                winner      = idx;
                grant[idx]  = 1'b1;
            end
        end
        rr_ptr_nxt = rr_ptr;
        if (grant_vld)
            rr_ptr_nxt = (winner == PW'(NUM_CH - 1)) ? '0 : winner + 1'b1;
    end

    always_comb begin
        busy_nxt = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            state_nxt[i] = state[i];
            cnt_nxt[i]   = cnt[i];
            case (state[i])
                OFF: begin
                    if (grant[i]) begin
                        state_nxt[i] = WAKE;
                        cnt_nxt[i]   = WAKE_LOAD;
                    end
                end
                WAKE: begin
                    if (cnt[i] == 4'd0)
                        state_nxt[i] = ON;
                    else
                        cnt_nxt[i] = cnt[i] - 4'd1;
                end
                ON: begin
                    if (!req[i]) begin
                        state_nxt[i] = HOLD;
                        cnt_nxt[i]   = IDLE_LOAD;
                    end
                end
                HOLD: begin
                    if (req[i])
                        state_nxt[i] = ON;
                    else if (cnt[i] == 4'd0)
                        state_nxt[i] = OFF;
                    else
                        cnt_nxt[i] = cnt[i] - 4'd1;
                end
                default: begin
                    state_nxt[i] = OFF;
                    cnt_nxt[i]   = 4'd0;
                end
            endcase
            // Outputs are registered from next state so they line up with the state register.
            gate_en_nxt[i] = force_on || (state_nxt[i] != OFF);
            ack_nxt[i]     = (state_nxt[i] == ON) || (state_nxt[i] == HOLD);
            busy_nxt       = busy_nxt || (state_nxt[i] != OFF);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state[i] <= OFF;
                cnt[i]   <= 4'd0;
            end
            rr_ptr  <= '0;
            gate_en <= '0;
            ack     <= '0;
            busy    <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                state[i] <= state_nxt[i];
                cnt[i]   <= cnt_nxt[i];
            end
            rr_ptr  <= rr_ptr_nxt;
            gate_en <= gate_en_nxt;
            ack     <= ack_nxt;
            busy    <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Bench for clk_gate_ctrl: per-cycle vector table plus hand sequences for arbitration corners.
module tb_clk_gate_ctrl;

    localparam int NUM_CH = 4;

    logic              clk;
    logic              reset_n;
    logic [NUM_CH-1:0] req;
    logic              force_on;
    logic [NUM_CH-1:0] gate_en;
    logic [NUM_CH-1:0] ack;
    logic              busy;

    int total = 0;
    int bad   = 0;

    clk_gate_ctrl #(.NUM_CH(NUM_CH), .WAKE_CYCLES(2), .IDLE_CYCLES(8)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req      (req),
        .force_on (force_on),
        .gate_en  (gate_en),
        .ack      (ack),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] g;
        logic [3:0] a;
        logic       b;
    } exp_t;

    typedef struct {
        logic [3:0] rq;
        logic       frc;
        logic       rst;
        int         reps;
        logic [3:0] g;
        logic [3:0] a;
        logic       b;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, queue the expectation, compare after the edge.
    task automatic step(input logic [3:0] rq, input logic frc, input logic rst,
                        input logic [3:0] g, input logic [3:0] a, input logic b,
                        input string tag);
        exp_t e;
        @(negedge clk);
        req      = rq;
        force_on = frc;
        reset_n  = rst;
        sb.push_back('{g: g, a: a, b: b});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, ".gate_en"}, 32'(gate_en), 32'(e.g));
        chk({tag, ".ack"},     32'(ack),     32'(e.a));
        chk({tag, ".busy"},    32'(busy),    32'(e.b));
    endtask

    function automatic void add(input logic [3:0] rq, input logic frc, input logic rst, input int reps,
                                input logic [3:0] g, input logic [3:0] a, input logic b);
        vecs.push_back('{rq: rq, frc: frc, rst: rst, reps: reps, g: g, a: a, b: b});
    endfunction

    initial begin
        bit seen;
        reset_n  = 1'b0;
        req      = '0;
        force_on = 1'b0;

        // Reset and single wake/release on ch0: gate at +1, ack at +3, off 9 edges after req drops.
        add(4'h0, 0, 0, 2, 4'h0, 4'h0, 0);
        add(4'h0, 0, 1, 2, 4'h0, 4'h0, 0);
        add(4'h1, 0, 1, 2, 4'h1, 4'h0, 1);
        add(4'h1, 0, 1, 8, 4'h1, 4'h1, 1);
        add(4'h0, 0, 1, 8, 4'h1, 4'h1, 1);
        add(4'h0, 0, 1, 2, 4'h0, 4'h0, 0);
        // force_on with everything idle.
        add(4'h0, 1, 1, 2, 4'hF, 4'h0, 0);
        add(4'h0, 0, 1, 1, 4'h0, 4'h0, 0);
        // Re-request during HOLD on ch1 keeps ack high without a new wake.
        add(4'h0, 0, 0, 1, 4'h0, 4'h0, 0);
        add(4'h2, 0, 1, 2, 4'h2, 4'h0, 1);
        add(4'h2, 0, 1, 2, 4'h2, 4'h2, 1);
        add(4'h0, 0, 1, 3, 4'h2, 4'h2, 1);
        add(4'h2, 0, 1, 3, 4'h2, 4'h2, 1);
        add(4'h0, 0, 1, 8, 4'h2, 4'h2, 1);
        add(4'h0, 0, 1, 1, 4'h0, 4'h0, 0);
        // ch3: force_on while active, reset in HOLD (counter 5) with force_on ignored, then full re-wake.
        add(4'h0, 0, 0, 1, 4'h0, 4'h0, 0);
        add(4'h8, 0, 1, 2, 4'h8, 4'h0, 1);
        add(4'h8, 0, 1, 1, 4'h8, 4'h8, 1);
        add(4'h8, 1, 1, 1, 4'hF, 4'h8, 1);
        add(4'h8, 0, 1, 1, 4'h8, 4'h8, 1);
        add(4'h0, 0, 1, 3, 4'h8, 4'h8, 1);
        add(4'h8, 1, 0, 1, 4'h0, 4'h0, 0);
        add(4'h8, 0, 1, 2, 4'h8, 4'h0, 1);
        add(4'h8, 0, 1, 1, 4'h8, 4'h8, 1);

        foreach (vecs[i]) begin
            for (int r = 0; r < vecs[i].reps; r++)
                step(vecs[i].rq, vecs[i].frc, vecs[i].rst, vecs[i].g, vecs[i].a, vecs[i].b,
                     $sformatf("vec%0d.%0d", i, r));
        end

        // Simultaneous wake: one channel per cycle in index order, pointer wraps to 0.
        step(4'h0, 0, 0, 4'h0, 4'h0, 0, "sim.rst");
        step(4'hF, 0, 1, 4'h1, 4'h0, 1, "sim.c1");
        chk("sim.rr_ptr1", 32'(dut.rr_ptr), 32'd1);
        step(4'hF, 0, 1, 4'h3, 4'h0, 1, "sim.c2");
        step(4'hF, 0, 1, 4'h7, 4'h1, 1, "sim.c3");
        step(4'hF, 0, 1, 4'hF, 4'h3, 1, "sim.c4");
        chk("sim.rr_ptr4", 32'(dut.rr_ptr), 32'd0);
        step(4'hF, 0, 1, 4'hF, 4'h7, 1, "sim.c5");
        step(4'hF, 0, 1, 4'hF, 4'hF, 1, "sim.c6");

        // Fairness: ch0 and ch2 contend; ch2 must be granted within NUM_CH cycles.
        step(4'h0, 0, 0, 4'h0, 4'h0, 0, "fair.rst");
        step(4'h5, 0, 1, 4'h1, 4'h0, 1, "fair.c1");
        seen = 1'b0;
        for (int n = 0; n < NUM_CH && !seen; n++) begin
            @(negedge clk);
            req = 4'h5;
            @(posedge clk);
            #1;
            if (gate_en[2]) seen = 1'b1;
        end
        chk("fair.ch2_granted", 32'(seen), 32'd1);
        chk("fair.ch0_kept", 32'(gate_en[0]), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
